// File: rtl/inst_mem_arbiter.sv
// Arbiter for the shared single-port instruction memory.
// The core fetch port has priority; the host port is asynchronous to clk,
// uses a 4-phase req/ack handshake through a synchronizer, and is
// guaranteed a slot after STARVE_LIMIT consecutive core wins.
module inst_mem_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          clk,
    input  logic          start_rst,
    // host port (asynchronous, 4-phase handshake)
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    // core fetch port
    input  logic          core_req,
    input  logic [AW-1:0] core_addr,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    // memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Starvation counter only needs to reach STARVE_LIMIT.
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        H_IDLE,
        H_WAIT,
        H_READ,
        H_ACK
    } host_state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    host_state_e state_q, state_d;
    logic          host_ack_q, host_ack_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          core_rvalid_q;

    // Host request fields, captured once the synchronized request is seen.
    logic          hwe_q;
    logic [AW-1:0] haddr_q;
    logic [DW-1:0] hwdata_q;
    logic          cap_en;

    logic host_elig;
    logic host_win;
    logic core_win;

    assign req_s  = sync_q[SYNC_STAGES-1];
    assign cap_en = (state_q == H_IDLE) && req_s;

    // Synchronizer chain bringing host_req into the clk domain.
    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            sync_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            sync_q <= {sync_q[SYNC_STAGES-2:0], host_req};
        end
    end

    // Arbitration: core first, host forced in once the core has won STARVE_LIMIT times in a row.
    always_comb begin
        host_elig = (state_q == H_WAIT);
        host_win  = host_elig && (!core_req || (starve_q == STARVE_MAX));
        core_win  = core_req && !host_win;
    end

    // Host FSM next state, registered ack/read data and starvation count.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        host_rdata_d = host_rdata_q;
        starve_d     = '0;

        case (state_q)
            H_IDLE: if (req_s) state_d = H_WAIT;
            H_WAIT: if (host_win) state_d = hwe_q ? H_ACK : H_READ;
            H_READ: begin
                host_rdata_d = mem_rdata;
                state_d      = H_ACK;
            end
            H_ACK:  if (!req_s) state_d = H_IDLE;
            default: state_d = H_IDLE;
        endcase

        if (host_elig && core_win) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
        end

        host_ack_d = (state_d == H_ACK);
    end

    // Host FSM state and its registered outputs.
    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            state_q      <= H_IDLE;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            starve_q     <= starve_d;
        end
    end

    // Capture the quasi-static host fields when the request is first seen.
    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            // NOTE: these are plain data holding registers; they are reset
            // only to keep simulation free of X, nothing depends on the value.
            hwe_q    <= 1'b0;
            haddr_q  <= '0;
            hwdata_q <= '0;
        end else if (cap_en) begin
            hwe_q    <= host_we;
            haddr_q  <= host_addr;
            hwdata_q <= host_wdata;
        end
    end

    // Core read data is valid one cycle after its grant.
    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            core_rvalid_q <= 1'b0;
        end else begin
            core_rvalid_q <= core_win;
        end
    end

    assign mem_en    = host_win || core_win;
    assign mem_we    = host_win && hwe_q;
    assign mem_addr  = host_win ? haddr_q : core_addr;
    assign mem_wdata = host_win ? hwdata_q : '0;

    assign core_gnt    = core_win;
    assign core_rvalid = core_rvalid_q;
    assign core_rdata  = mem_rdata;

    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Self-checking bench for inst_mem_arbiter: directed handshake, starvation
// and reset scenarios followed by randomized host/core traffic, all checked
// against a cycle-level model built from the arbitration rules.
module tb_inst_mem_arbiter;

    localparam int LIMIT = 4;
    localparam int SYNC  = 2;
    localparam int ELIG  = SYNC + 1;  // first cycle the host may win

    logic       clk = 1'b0;
    logic       start_rst;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       core_req;
    logic [7:0] core_addr;
    logic       core_gnt, core_rvalid;
    logic [7:0] core_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata;

    // second instance, host always wins
    logic       z_host_req, z_host_we;
    logic [7:0] z_host_addr, z_host_wdata;
    logic       z_host_ack;
    logic [7:0] z_host_rdata;
    logic       z_core_req;
    logic [7:0] z_core_addr;
    logic       z_core_gnt, z_core_rvalid;
    logic [7:0] z_core_rdata;
    logic       z_mem_en, z_mem_we;
    logic [7:0] z_mem_addr, z_mem_wdata;
    logic [7:0] z_mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // scoreboard state
    logic [7:0] ref_mem [256];
    logic [7:0] exp_host_rdata;
    logic [7:0] exp_core_rdata;
    bit         exp_rvalid;
    bit         core_hold;

    inst_mem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(LIMIT), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .start_rst(start_rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    inst_mem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(0), .SYNC_STAGES(SYNC)) dut_z (
        .clk(clk), .start_rst(start_rst),
        .host_req(z_host_req), .host_we(z_host_we), .host_addr(z_host_addr),
        .host_wdata(z_host_wdata), .host_ack(z_host_ack), .host_rdata(z_host_rdata),
        .core_req(z_core_req), .core_addr(z_core_addr), .core_gnt(z_core_gnt),
        .core_rvalid(z_core_rvalid), .core_rdata(z_core_rdata),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 37 + 11);
    endfunction

    // Behavioural single-port memory with one cycle read latency.
    logic [7:0] tb_mem [256];
    bit         mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Pick this cycle's core request; an ungranted request is held.
    task automatic drive_core(input int density);
        if (!core_hold) begin
            core_req  = ($urandom_range(99) < density);
            core_addr = 8'($urandom);
        end
    endtask

    // Check one cycle given whether the host is expected to win it, then advance.
    task automatic tick(input bit hwin, input bit h_we, input logic [7:0] h_addr,
                        input logic [7:0] h_wdata);
        #2;
        check("core_gnt", core_gnt, core_req && !hwin);
        check("mem_en", mem_en, core_req || hwin);
        if (hwin) begin
            check("host_mem_we", mem_we, h_we);
            check("host_mem_addr", mem_addr, h_addr);
            if (h_we) begin
                check("host_mem_wdata", mem_wdata, h_wdata);
                ref_mem[h_addr] = h_wdata;
            end
        end else begin
            check("mem_we_idle", mem_we, 1'b0);
            if (core_req) check("core_mem_addr", mem_addr, core_addr);
        end
        check("core_rvalid", core_rvalid, exp_rvalid);
        if (exp_rvalid) check("core_rdata", core_rdata, exp_core_rdata);
        exp_rvalid     = core_req && !hwin;
        exp_core_rdata = ref_mem[core_addr];
        core_hold      = core_req && hwin;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One full host handshake with concurrent core traffic of the given density.
    task automatic host_txn(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                            input int density);
        int  g;
        int  ack_k;
        bit  hwin;
        bit  done;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        host_req   = 1'b1;
        g     = -1;
        ack_k = -1;
        done  = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            drive_core(density);
            // Host wins the first eligible cycle with no core request, or
            // once the core has already won LIMIT cycles in a row.
            hwin = (g < 0) && (k >= ELIG) && (!core_req || (k - ELIG) == LIMIT);
            if (hwin) begin
                g     = k;
                ack_k = k + (we ? 1 : 2);
            end
            check("host_ack", host_ack, (ack_k >= 0) && (k >= ack_k));
            if (k == ack_k) begin
                if (!we) exp_host_rdata = ref_mem[addr];
                check("host_rdata", host_rdata, exp_host_rdata);
                done = 1'b1;
            end
            tick(hwin, we, addr, wdata);
        end
        check("host_ack_timeout", done, 1'b1);
        host_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            drive_core(density);
            check("host_ack_fall", host_ack, j < 3);
            tick(1'b0, we, addr, wdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dens [4] = '{0, 25, 60, 100};

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        exp_host_rdata = 8'h00;
        exp_core_rdata = 8'h00;
        exp_rvalid     = 1'b0;
        core_hold      = 1'b0;

        start_rst  = 1'b1;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 8'h00;
        host_wdata = 8'h00;
        core_req   = 1'b0;
        core_addr  = 8'h00;
        z_host_req   = 1'b0;
        z_host_we    = 1'b1;
        z_host_addr  = 8'h33;
        z_host_wdata = 8'h77;
        z_core_req   = 1'b0;
        z_core_addr  = 8'h21;
        z_mem_rdata  = 8'h5A;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_host_ack", host_ack, 1'b0);
        check("rst_host_rdata", host_rdata, 8'h00);
        check("rst_core_rvalid", core_rvalid, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_core_gnt", core_gnt, 1'b0);
        start_rst = 1'b0;
        @(posedge clk);
        #1;

        // uncontended write then read of 0x10
        host_txn(1'b1, 8'h10, 8'hA5, 0);
        host_txn(1'b0, 8'h10, 8'h00, 0);

        // core read of 0x10 with host idle
        core_req  = 1'b1;
        core_addr = 8'h10;
        tick(1'b0, 1'b0, 8'h00, 8'h00);
        core_req = 1'b0;
        check("core_read_a5", core_rdata, 8'hA5);
        tick(1'b0, 1'b0, 8'h00, 8'h00);

        // starvation: core saturates, host must still get in; repeated to
        // show the counter restarts from zero
        host_txn(1'b1, 8'h40, 8'h3C, 100);
        host_txn(1'b1, 8'h41, 8'hC3, 100);
        host_txn(1'b0, 8'h40, 8'h00, 100);

        // host-always-wins build: both requesting, host goes first
        z_host_req = 1'b1;
        z_core_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #2;
            check("z_core_gnt", z_core_gnt, k != 3);
            check("z_mem_en", z_mem_en, 1'b1);
            check("z_mem_we", z_mem_we, k == 3);
            if (k == 3) begin
                check("z_mem_addr", z_mem_addr, 8'h33);
                check("z_mem_wdata", z_mem_wdata, 8'h77);
            end
            check("z_core_rvalid", z_core_rvalid, (k >= 1) && (k != 4));
            check("z_host_ack", z_host_ack, k >= 4);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("z_core_rdata", z_core_rdata, 8'h5A);
        check("z_host_rdata", z_host_rdata, 8'h00);
        z_host_req = 1'b0;
        z_core_req = 1'b0;

        // give host_rdata a known non-zero value before the reset test
        host_txn(1'b1, 8'h20, 8'h5C, 0);
        host_txn(1'b0, 8'h20, 8'h00, 0);

        // reset while the host read sits in its data-capture cycle
        host_we   = 1'b0;
        host_addr = 8'h10;
        host_req  = 1'b1;
        for (int k = 0; k < ELIG + 1; k++) begin
            core_req = 1'b0;
            tick(k == ELIG, 1'b0, 8'h10, 8'h00);
        end
        core_req  = 1'b1;
        core_addr = 8'h44;
        #2;
        check("rd_cycle_core_gnt", core_gnt, 1'b1);
        start_rst = 1'b1;
        #1;
        check("midrst_host_ack", host_ack, 1'b0);
        check("midrst_host_rdata", host_rdata, 8'h00);
        check("midrst_core_rvalid", core_rvalid, 1'b0);
        core_req = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        check("inrst_host_ack", host_ack, 1'b0);
        check("inrst_host_rdata", host_rdata, 8'h00);
        check("inrst_core_rvalid", core_rvalid, 1'b0);
        start_rst      = 1'b0;
        exp_host_rdata = 8'h00;
        exp_rvalid     = 1'b0;
        core_hold      = 1'b0;
        host_txn(1'b0, 8'h10, 8'h00, 0);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            int d;
            d = dens[$urandom_range(3)];
            host_txn(1'($urandom_range(1)), 8'($urandom), 8'($urandom), d);
            for (int gap = 0; gap < int'($urandom_range(3)); gap++) begin
                drive_core(d);
                tick(1'b0, 1'b0, 8'h00, 8'h00);
            end
        end

        // drain any held core request
        core_hold = 1'b0;
        core_req  = 1'b0;
        tick(1'b0, 1'b0, 8'h00, 8'h00);
        tick(1'b0, 1'b0, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_mem_arbiter.md
Name: inst_mem_arbiter

Overview:
- Sits between the I2C configuration path and the shared single-port instruction memory.
- Shares that memory between two requesters: the host port, fed from the I2C register block and asynchronous to clk, and the core fetch port, synchronous to clk.
- The host port uses a 4-phase req/ack handshake through an internal synchronizer.
- The core port has priority, but the host is guaranteed a slot after STARVE_LIMIT consecutive core wins.

Parameters:
AW, 8, memory address width
DW, 8, memory data width
STARVE_LIMIT, 4, max consecutive core grants while host waits; 0 = host always wins
SYNC_STAGES, 2, flops in host_req synchronizer (>=2)

Ports:
clk  in  1  system clock
start_rst  in  1  reset, asynchronous, active-high
host_req  in  1  async host request (level, 4-phase)
host_we  in  1  host write(1)/read(0); stable while host_req high
host_addr  in  AW  host address; stable while host_req high
host_wdata  in  DW  host write data; stable while host_req high
host_ack  out  1  host handshake acknowledge
host_rdata  out  DW  host read result, valid while host_ack high
core_req  in  1  core fetch request
core_addr  in  AW  core fetch address
core_gnt  out  1  core request accepted this cycle (combinational)
core_rvalid  out  1  core_rdata valid
core_rdata  out  DW  core fetch data
mem_en  out  1  memory enable (combinational)
mem_we  out  1  memory write enable (combinational)
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, 1-cycle latency after mem_en

Behaviour:
- Reset values:
  - host_ack=0, host_rdata=0, core_rvalid=0.
  - Synchronizer flops=0, host FSM=H_IDLE, starve_cnt=0.
  - mem_en/mem_we/core_gnt=0 because no requester is eligible.
- Synchronizer: host_req passes SYNC_STAGES flops, giving req_s. host_we, host_addr and host_wdata are sampled only while req_s=1; no synchronization is needed because they are quasi-static.
- Host FSM:
  - H_IDLE: req_s=1 -> H_WAIT.
  - H_WAIT: host eligible. On host_win, drive the memory access this cycle. Write -> H_ACK. Read -> H_READ.
  - H_READ: capture mem_rdata into host_rdata -> H_ACK.
  - H_ACK: host_ack=1 (registered). When req_s=0, clear host_ack -> H_IDLE.
- Arbitration, evaluated each cycle:
  - Only core_req -> core wins.
  - Only host in H_WAIT -> host wins.
  - Both -> core wins unless starve_cnt==STARVE_LIMIT, then host wins.
- starve_cnt: increment (saturating) when the core wins while the host is in H_WAIT. Clear when the host wins, or when the host is not in H_WAIT.
- Memory drive:
  - Winner's address/data go to mem_*.
  - mem_we=1 only for a host write.
  - mem_en=1 on any grant.
- Core path:
  - core_gnt=core_req && core_win.
  - core_rvalid is registered core_gnt, so it is high exactly 1 cycle after the grant.
  - core_rdata=mem_rdata passthrough; defined only when core_rvalid=1.
  - A core that is not granted holds core_req/core_addr and retries.
- host_rdata holds its value until the next host read completes. Writes do not alter it.
- Latency:
  - Uncontended write: ack rises SYNC_STAGES+2 clk after host_req rises.
  - Uncontended read: ack rises SYNC_STAGES+3 clk after host_req rises.
- Host deassertion: dropping host_req before host_ack is a protocol violation. The block completes the access anyway.
- Simultaneous events: host_win and core_req in the same cycle -> core_gnt=0, core retries the next cycle.
- Reset mid-operation:
  - All state clears; an in-flight host read result is lost.
  - If host_req is still high after release, the transaction is re-executed from H_IDLE.

Test Plan:
- Host write addr 0x10 data 0xA5, core idle -> single-cycle mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5. host_ack rises 4 clk after host_req. host_ack falls 3 clk after host_req falls.
- Host read addr 0x10 after the write -> mem_we=0 grant cycle, host_rdata=0xA5 when host_ack rises (5 clk after req).
- Core read addr 0x10, host idle -> core_gnt=1 same cycle, core_rvalid=1 next cycle, core_rdata=0xA5.
- core_req held high with incrementing addresses, host write pending -> 4 consecutive core_gnt. 5th cycle core_gnt=0 and mem_we=1 with the host addr. Core resumes next cycle. starve_cnt returns to 0.
- STARVE_LIMIT=0 build, core and host both pending -> host granted first, core_gnt next cycle.
- start_rst pulsed while FSM in H_READ, host_req held high -> host_ack=0, host_rdata=0, core_rvalid=0 during reset. The read re-executes after release. host_ack rises with the correct data.
